// File: rtl/ring_frequency_meter_if.sv
// ring_frequency_meter_if
// Control and result bundle between a measurement requester and the
// ring-oscillator frequency meter.
//   start    : request a measurement (requester -> meter)
//   busy     : measurement in progress (meter -> requester)
//   done     : one-cycle pulse when count/overflow update
//   count    : rising edges counted in the last window (saturating)
//   overflow : last window saturated count
interface ring_frequency_meter_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (output start, input busy, done, count, overflow);
    modport slave  (input start, output busy, done, count, overflow);
endinterface

// File: rtl/ring_frequency_meter.sv
// ring_frequency_meter
// Enables a ring oscillator, waits a settle window, then counts oscillator
// rising edges over a fixed gate window of clk cycles and reports the count.
//
// Ports:
//   clk    : system clock
//   rst    : synchronous reset, active-high
//   osc_in : oscillator output, asynchronous to clk
//   osc_en : oscillator enable, drives the ring's en input
//   bus    : slave side of ring_frequency_meter_if (start/busy/done/count/overflow)
//
// Build option: define RING_METER_CONTINUOUS_EN to allow back-to-back windows
// (DONE goes straight to MEASURE while start is held high).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | oscillator off, waiting for start
// SETTLE  | oscillator on, letting it stabilise
// MEASURE | gate window open, counting synchronized edges
// DONE    | one cycle, count/overflow just loaded, done=1
module ring_frequency_meter #(
    parameter int GATE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  osc_in,
    output logic                  osc_en,
    ring_frequency_meter_if.slave bus
);
    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic             tc;
    logic             s1, s2, s3;
    logic             e;
    logic             inc;
    logic             sat;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             enter_measure;

    assign tc            = (timer_q == '0);
    assign e             = s2 & ~s3;
    assign enter_measure = (state_d == MEASURE) && (state_q != MEASURE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SETTLE;
            SETTLE:  if (tc) state_d = MEASURE;
            MEASURE: if (tc) state_d = DONE;
            DONE: begin
`ifdef RING_METER_CONTINUOUS_EN
                state_d = bus.start ? MEASURE : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic; DONE keeps the ring running so back-to-back windows
    // never glitch the enable.
    always_comb begin
        osc_en   = (state_q != IDLE);
        bus.busy = (state_q != IDLE);
        bus.done = (state_q == DONE);
    end

    // Shared down-counter: loaded with length-1 on entry to SETTLE/MEASURE,
    // terminal count ends the phase.
    always_ff @(posedge clk) begin
        if (rst)                                       timer_q <= '0;
        else if (state_q == IDLE && state_d == SETTLE) timer_q <= TW'(SETTLE_CYCLES - 1);
        else if (enter_measure)                        timer_q <= TW'(GATE_CYCLES - 1);
        else if (!tc)                                  timer_q <= timer_q - 1'b1;
    end

    // Synchronizer plus history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Saturating edge counter; overflow flags an edge lost at the ceiling.
    assign inc = (state_q == MEASURE) && e;
    assign sat = (edge_q == CNT_MAX);

    always_comb begin
        edge_d = edge_q + CNT_W'(inc && !sat);
        ovf_d  = ovf_q | (inc & sat);
    end

    always_ff @(posedge clk) begin
        if (rst || enter_measure) begin
            edge_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
        end
    end

    // Results are captured from the next-value so an edge in the last gate
    // cycle is included and the new count is visible during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (state_q == MEASURE && tc) begin
            count_q    <= edge_d;
            overflow_q <= ovf_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_ring_frequency_meter.sv
module tb_ring_frequency_meter;
    localparam int S   = 16;
    localparam int GA  = 64;
    localparam int GB  = 128;

    logic clk;
    logic rst;
    logic osc_a, osc_b;
    logic en_a, en_b;
    int   half_a, half_b;
    int   nchecks;
    int   nerr;

    ring_frequency_meter_if #(.CNT_W(16)) ifa ();
    ring_frequency_meter_if #(.CNT_W(4))  ifb ();

    ring_frequency_meter #(.GATE_CYCLES(GA), .SETTLE_CYCLES(S), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .osc_in(osc_a), .osc_en(en_a), .bus(ifa.slave)
    );
    ring_frequency_meter #(.GATE_CYCLES(GB), .SETTLE_CYCLES(S), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .osc_in(osc_b), .osc_en(en_b), .bus(ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Oscillator models: toggle every half_x clk cycles, frozen when 0.
    initial begin
        int c;
        c = 0;
        osc_a = 1'b0;
        forever begin
            @(negedge clk);
            if (half_a != 0) begin
                if (c >= half_a - 1) begin osc_a = ~osc_a; c = 0; end
                else c = c + 1;
            end
        end
    end
    initial begin
        int c;
        c = 0;
        osc_b = 1'b0;
        forever begin
            @(negedge clk);
            if (half_b != 0) begin
                if (c >= half_b - 1) begin osc_b = ~osc_b; c = 0; end
                else c = c + 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic g_done(input int sel);
        return sel != 0 ? ifb.done : ifa.done;
    endfunction
    function automatic logic g_busy(input int sel);
        return sel != 0 ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic g_en(input int sel);
        return sel != 0 ? en_b : en_a;
    endfunction
    function automatic longint g_count(input int sel);
        return sel != 0 ? longint'(ifb.count) : longint'(ifa.count);
    endfunction
    function automatic logic g_ovf(input int sel);
        return sel != 0 ? ifb.overflow : ifa.overflow;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) ifb.start = v;
        else          ifa.start = v;
    endtask

    // Pulse start; n counts edges after the sampling edge, sampled #1 later.
    task automatic pulse_start(input int sel);
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    typedef struct {
        string  name;
        int     sel;
        int     half;
        longint exp_count;
        logic   exp_ovf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, ndone, first_n;
        longint cnt;
        logic ov;
        logic en_ok;
        int dn[$];

        nchecks = 0;
        nerr    = 0;
        half_a  = 0;
        half_b  = 0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;

        vecs[0] = '{"a_half4",  0, 4,  8,  1'b0};
        vecs[1] = '{"a_half8",  0, 8,  4,  1'b0};
        vecs[2] = '{"a_half2",  0, 2,  16, 1'b0};
        vecs[3] = '{"b_sat",    1, 2,  15, 1'b1};
        vecs[4] = '{"b_half16", 1, 16, 4,  1'b0};
        vecs[5] = '{"b_half8",  1, 8,  8,  1'b0};

        // Reset held with start asserted
        rst = 1'b1;
        ifa.start = 1'b1;
        ifb.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rst_osc_en", {en_a, en_b}, 0);
        chk("rst_busy", {ifa.busy, ifb.busy}, 0);
        chk("rst_done", {ifa.done, ifb.done}, 0);
        chk("rst_count", ifa.count + ifb.count, 0);
        chk("rst_ovf", {ifa.overflow, ifb.overflow}, 0);
        @(negedge clk);
        rst = 1'b0;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", {ifa.busy, ifb.busy, en_a, en_b}, 0);

        // Table-driven measurements
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].sel != 0) half_b = vecs[v].half;
            else                  half_a = vecs[v].half;
            lat = S + ((vecs[v].sel != 0) ? GB : GA);
            repeat (4) @(posedge clk);
            pulse_start(vecs[v].sel);
            ndone = 0; first_n = -1; cnt = -1; ov = 1'bx;
            for (int n = 0; n <= lat + 5; n++) begin
                if (g_done(vecs[v].sel)) begin
                    ndone++;
                    if (first_n < 0) begin
                        first_n = n;
                        cnt = g_count(vecs[v].sel);
                        ov  = g_ovf(vecs[v].sel);
                    end
                end
                if (n == 0)       chk({vecs[v].name, "_en_rise"}, g_en(vecs[v].sel), 1);
                if (n == lat)     chk({vecs[v].name, "_en_done"}, g_en(vecs[v].sel), 1);
                if (n == lat + 1) chk({vecs[v].name, "_en_fall"},
                                      {g_en(vecs[v].sel), g_busy(vecs[v].sel)}, 0);
                @(posedge clk);
                #1;
            end
            chk({vecs[v].name, "_done_cycle"}, first_n, lat);
            chk({vecs[v].name, "_ndone"}, ndone, 1);
            chk({vecs[v].name, "_count"}, cnt, vecs[v].exp_count);
            chk({vecs[v].name, "_ovf"}, ov, vecs[v].exp_ovf);
            chk({vecs[v].name, "_count_hold"}, g_count(vecs[v].sel), vecs[v].exp_count);
        end

        // Start re-pulsed during MEASURE is ignored
        half_a = 4;
        lat = S + GA;
        pulse_start(0);
        ndone = 0; first_n = -1;
        for (int n = 0; n < 200; n++) begin
            if (ifa.done) begin ndone++; if (first_n < 0) first_n = n; end
            if (n == 30) ifa.start = 1'b1;
            if (n == 31) ifa.start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("ignore_ndone", ndone, 1);
        chk("ignore_done_cycle", first_n, lat);

        // Reset in the middle of the window
        pulse_start(0);
        for (int n = 0; n < 39; n++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_pre_busy", ifa.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_en", en_a, 0);
        chk("midrst_busy", ifa.busy, 0);
        chk("midrst_count", ifa.count, 0);
        ndone = 0;
        for (int n = 0; n < 200; n++) begin
            if (ifa.done || ifa.busy) ndone++;
            @(posedge clk);
            #1;
        end
        chk("midrst_no_done", ndone, 0);

`ifdef RING_METER_CONTINUOUS_EN
        // Back-to-back windows while start is held
        half_a = 4;
        repeat (4) @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b1;
        @(posedge clk);
        #1;
        en_ok = 1'b1;
        for (int n = 0; n <= 280; n++) begin
            if (ifa.done) begin
                dn.push_back(n);
                chk("cont_count", ifa.count, 8);
            end
            if (n <= 275 && !en_a) en_ok = 1'b0;
            if (n == 240) ifa.start = 1'b0;
            if (n == 276) chk("cont_idle_after_drop", {ifa.busy, en_a}, 0);
            @(posedge clk);
            #1;
        end
        chk("cont_ndone", dn.size(), 4);
        if (dn.size() == 4) begin
            chk("cont_done0", dn[0], 80);
            chk("cont_done1", dn[1], 145);
            chk("cont_done2", dn[2], 210);
            chk("cont_done3", dn[3], 275);
        end
        chk("cont_en_steady", en_ok, 1);
`else
        en_ok = 1'b1;
        dn.delete();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end
endmodule
